// File: rtl/ss_pkg.sv
// ss_pkg: shared state type and width helper for the window accumulator
package ss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_OUT
    } state_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/ss_detect_edge.sv
// ss_detect_edge: single-bit rising/falling edge detector with registered output
module ss_detect_edge #(
    parameter bit RISE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic prev_q, prev_d;
    logic edge_q, edge_d;

    // The history flop resets to the "already asserted" level so a level held
    // through reset release is not mistaken for a fresh edge.
    always_comb begin
        prev_d = i_sig;
        edge_d = RISE ? (i_sig & ~prev_q) : (~i_sig & prev_q);
    end

    // Register input history and the detected edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= RISE;
            edge_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign o_edge = edge_q;

endmodule

// File: rtl/ss_accum_window.sv
// ss_accum_window: multi-channel windowed accumulator with saturate/wrap and result handshake
module ss_accum_window
    import ss_pkg::*;
#(
    parameter int SIZE_DATA = 8,
    parameter int N_CH      = 4,
    parameter int MAX_LEN   = 256,
    parameter int SIZE_SUM  = SIZE_DATA + $clog2(MAX_LEN)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [len_w(MAX_LEN)-1:0]  i_len,
    input  logic                       i_mode_sat,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [N_CH*SIZE_DATA-1:0]  i_data,
    output logic [N_CH*SIZE_SUM-1:0]   o_sum,
    output logic                       o_sum_valid,
    input  logic                       i_sum_ready,
    output logic [N_CH-1:0]            o_ovf,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int LW  = len_w(MAX_LEN);
    localparam int SW1 = SIZE_SUM + 1;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            sat_q, sat_d;
    logic            sum_valid_q, sum_valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            start_edge;
    logic            len_ok;
    logic            start_ok;
    logic            hs;
    logic            last;

    ss_detect_edge #(.RISE(1'b1)) u_start_edge (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_sig  (i_start),
        .o_edge (start_edge)
    );

    assign len_ok   = (i_len != '0) && (i_len <= LW'(MAX_LEN));
    assign start_ok = (state_q == ST_IDLE) && start_edge && len_ok;
    assign hs       = (state_q == ST_ACCUM) && i_valid;
    assign last     = hs && (cnt_q == len_q - LW'(1));

    // Next-state and control: start acceptance, sample counting, result handshake
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        sum_valid_d = sum_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    if (len_ok) begin
                        state_d = ST_ACCUM;
                        len_d   = i_len;
                        sat_d   = i_mode_sat;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (hs) begin
                    cnt_d = cnt_q + LW'(1);
                    if (last) begin
                        state_d     = ST_OUT;
                        sum_valid_d = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (i_sum_ready) begin
                    state_d     = ST_IDLE;
                    sum_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            sum_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            sum_valid_q <= sum_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SIZE_SUM-1:0] acc_q, acc_d;
        logic [SIZE_SUM-1:0] sum_q, sum_d;
        logic [SIZE_SUM-1:0] add_res;
        logic [SIZE_SUM:0]   ext;
        logic                add_ovf;
        logic                ovf_q, ovf_d;

        // One extra bit on the adder exposes the carry used for both clamp and overflow flag
        always_comb begin
            ext     = {1'b0, acc_q} + SW1'(i_data[c*SIZE_DATA +: SIZE_DATA]);
            add_ovf = ext[SIZE_SUM];
            add_res = (add_ovf && sat_q) ? '1 : ext[SIZE_SUM-1:0];
            acc_d   = start_ok ? '0 : hs ? add_res : acc_q;
            ovf_d   = start_ok ? 1'b0 : (ovf_q | (hs & add_ovf));
            sum_d   = last ? add_res : sum_q;
        end

        // Per-channel accumulator, sticky overflow and result registers
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
                sum_q <= '0;
            end else begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
                sum_q <= sum_d;
            end
        end

        assign o_sum[c*SIZE_SUM +: SIZE_SUM] = sum_q;
        assign o_ovf[c]                      = ovf_q;
    end

    assign o_ready     = (state_q == ST_ACCUM);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_sum_valid = sum_valid_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_ss_accum_window.sv
// tb_ss_accum_window: directed self-checking bench for the window accumulator
module tb_ss_accum_window;

    localparam int SD = 8;
    localparam int NC = 4;
    localparam int ML = 256;
    localparam int SS = 9;
    localparam int LW = $clog2(ML) + 1;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_start;
    logic [LW-1:0]      i_len;
    logic               i_mode_sat;
    logic               i_valid;
    logic               o_ready;
    logic [NC*SD-1:0]   i_data;
    logic [NC*SS-1:0]   o_sum;
    logic               o_sum_valid;
    logic               i_sum_ready;
    logic [NC-1:0]      o_ovf;
    logic               o_busy;
    logic               o_done;
    logic               o_err;

    int n_cmp = 0;
    int n_bad = 0;

    ss_accum_window #(
        .SIZE_DATA(SD),
        .N_CH     (NC),
        .MAX_LEN  (ML),
        .SIZE_SUM (SS)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_len      (i_len),
        .i_mode_sat (i_mode_sat),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_sum      (o_sum),
        .o_sum_valid(o_sum_valid),
        .i_sum_ready(i_sum_ready),
        .o_ovf      (o_ovf),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [NC*SS-1:0] pk(input int a, input int b, input int c, input int d);
        return {SS'(d), SS'(c), SS'(b), SS'(a)};
    endfunction

    function automatic logic [NC*SD-1:0] dt(input int a, input int b, input int c, input int d);
        return {SD'(d), SD'(c), SD'(b), SD'(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_win(input int len, input logic sat);
        @(negedge i_clk);
        i_start    = 1'b1;
        i_len      = LW'(len);
        i_mode_sat = sat;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_mode_sat = 1'b0;
        i_valid = 1'b0; i_data = '0; i_sum_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rst_sum", 64'(o_sum), 64'(0));
        chk("rst_flags", 64'({o_sum_valid, o_busy, o_ready, o_done, o_err, o_ovf}), 64'(0));
        // start held high across reset release must not count as an edge
        i_start = 1'b1; i_len = LW'(4);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("held_start_idle", 64'({o_busy, o_err}), 64'(0));
        i_start = 1'b0;
        @(negedge i_clk);
        // basic window, len 4, continuous valid
        start_win(4, 1'b0);
        i_data = dt(1, 2, 3, 4);
        @(negedge i_clk);
        chk("accum_entry", 64'({o_busy, o_ready}), 64'(2'b11));
        i_valid = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("basic_not_yet", 64'(o_sum_valid), 64'(0));
        @(negedge i_clk);
        chk("basic_valid", 64'({o_sum_valid, o_ready}), 64'(2'b10));
        chk("basic_sum", 64'(o_sum), 64'(pk(4, 8, 12, 16)));
        chk("basic_ovf", 64'(o_ovf), 64'(0));
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("basic_done", 64'({o_done, o_sum_valid, o_busy}), 64'(3'b100));
        @(negedge i_clk);
        chk("basic_done_once", 64'(o_done), 64'(0));
        chk("basic_sum_kept", 64'(o_sum), 64'(pk(4, 8, 12, 16)));
        // gapped valid, len 3
        start_win(3, 1'b0);
        @(negedge i_clk);
        i_valid = 1'b1; i_data = dt(10, 0, 0, 0);
        @(negedge i_clk);
        chk("gap_hs1", 64'(o_sum_valid), 64'(0));
        i_valid = 1'b0;
        @(negedge i_clk);
        i_valid = 1'b1; i_data = dt(20, 0, 0, 0);
        @(negedge i_clk);
        chk("gap_hs2", 64'(o_sum_valid), 64'(0));
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("gap_idle_slot", 64'({o_sum_valid, o_ready}), 64'(2'b01));
        i_valid = 1'b1; i_data = dt(30, 0, 0, 0);
        @(negedge i_clk);
        chk("gap_valid", 64'(o_sum_valid), 64'(1));
        chk("gap_sum", 64'(o_sum), 64'(pk(60, 0, 0, 0)));
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("gap_done", 64'(o_done), 64'(1));
        // saturate mode
        start_win(3, 1'b1);
        @(negedge i_clk);
        i_valid = 1'b1; i_data = dt(255, 0, 0, 0);
        repeat (3) @(negedge i_clk);
        chk("sat_sum", 64'(o_sum), 64'(pk(511, 0, 0, 0)));
        chk("sat_ovf", 64'(o_ovf), 64'(4'b0001));
        i_valid = 1'b0;
        @(negedge i_clk);
        // wrap mode, overflow flag must clear on the new start
        start_win(3, 1'b0);
        @(negedge i_clk);
        chk("ovf_cleared", 64'(o_ovf), 64'(0));
        i_valid = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("wrap_sum", 64'(o_sum), 64'(pk(253, 0, 0, 0)));
        chk("wrap_ovf", 64'(o_ovf), 64'(4'b0001));
        i_valid = 1'b0;
        @(negedge i_clk);
        // rejected starts: len 0 and len above MAX_LEN
        start_win(0, 1'b0);
        @(negedge i_clk);
        chk("len0_err", 64'({o_err, o_busy}), 64'(2'b10));
        @(negedge i_clk);
        chk("len0_err_pulse", 64'({o_err, o_busy}), 64'(0));
        start_win(ML + 1, 1'b0);
        @(negedge i_clk);
        chk("lenbig_err", 64'({o_err, o_busy}), 64'(2'b10));
        @(negedge i_clk);
        // start edge during ACCUM is ignored
        start_win(4, 1'b0);
        i_data = dt(1, 2, 3, 4);
        @(negedge i_clk);
        i_valid = 1'b1;
        @(negedge i_clk);
        i_start = 1'b1; i_len = LW'(2);
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        chk("ign_no_err", 64'({o_err, o_sum_valid}), 64'(0));
        @(negedge i_clk);
        chk("ign_sum", 64'(o_sum), 64'(pk(4, 8, 12, 16)));
        i_valid = 1'b0; i_sum_ready = 1'b0; i_data = dt(9, 9, 9, 9);
        // result held while consumer stalls
        repeat (5) @(negedge i_clk);
        chk("stall_hold", 64'({o_sum_valid, o_busy, o_done}), 64'(3'b110));
        chk("stall_sum", 64'(o_sum), 64'(pk(4, 8, 12, 16)));
        // start edge coincident with done, len 1
        i_sum_ready = 1'b1; i_start = 1'b1; i_len = LW'(1);
        @(negedge i_clk);
        chk("coin_done", 64'(o_done), 64'(1));
        i_start = 1'b0; i_data = dt(7, 6, 5, 4);
        @(negedge i_clk);
        chk("coin_accepted", 64'({o_busy, o_ready}), 64'(2'b11));
        i_valid = 1'b1;
        @(negedge i_clk);
        chk("len1_sum", 64'({o_sum_valid, o_sum}), 64'({1'b1, pk(7, 6, 5, 4)}));
        i_valid = 1'b0;
        @(negedge i_clk);
        // reset mid-window discards partial sums
        start_win(4, 1'b0);
        i_data = dt(1, 2, 3, 4);
        @(negedge i_clk);
        i_valid = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_sum", 64'(o_sum), 64'(0));
        chk("midrst_flags", 64'({o_sum_valid, o_busy, o_ready, o_done, o_err, o_ovf}), 64'(0));
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        start_win(4, 1'b0);
        @(negedge i_clk);
        i_valid = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("post_rst_sum", 64'({o_sum_valid, o_sum}), 64'({1'b1, pk(4, 8, 12, 16)}));
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("post_rst_done", 64'(o_done), 64'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ss_accum_window.md
SS_ACCUM_WINDOW -- requirements
Module: ss_accum_window

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8: width of one channel sample, unsigned.
REQ-002 SHALL have parameter N_CH, default 4: number of parallel channels.
REQ-003 SHALL have parameter MAX_LEN, default 256: maximum samples per window.
REQ-004 SHALL have parameter SIZE_SUM, default SIZE_DATA+$clog2(MAX_LEN): per-channel sum width.
REQ-005 SHALL have ports i_clk, input, 1: clock, rising edge.
REQ-006 SHALL have ports i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports i_start, input, 1: level; a rising edge requests a new window.
REQ-008 SHALL have ports i_len, input, $clog2(MAX_LEN)+1: samples per window, valid range 1..MAX_LEN.
REQ-009 SHALL have ports i_mode_sat, input, 1: 1 = saturate, 0 = wrap.
REQ-010 SHALL have ports i_valid, input, 1: sample valid.
REQ-011 SHALL have ports o_ready, output, 1: sample accepted when i_valid&o_ready.
REQ-012 SHALL have ports i_data, input, N_CH*SIZE_DATA: packed samples, channel c at bits [c*SIZE_DATA +: SIZE_DATA].
REQ-013 SHALL have ports o_sum, output, N_CH*SIZE_SUM: packed sums, same packing rule.
REQ-014 SHALL have ports o_sum_valid, output, 1: o_sum valid.
REQ-015 SHALL have ports i_sum_ready, input, 1: consumer accepts o_sum.
REQ-016 SHALL have ports o_ovf, output, N_CH: per-channel overflow flag for the current or last window.
REQ-017 SHALL have ports o_busy, output, 1: high in ACCUM or OUT.
REQ-018 SHALL have ports o_done, output, 1: one-cycle pulse after the result handshake.
REQ-019 SHALL have ports o_err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-020 SHALL implement FSM with states IDLE, ACCUM and OUT.
REQ-021 Start-edge detection SHALL be registered: rise seen at edge k (i_start=1 at k, 0 at k-1) -> state ACCUM from edge k+1.
REQ-022 On an accepted start: SHALL latch i_len and i_mode_sat, clear all accumulators, counter and o_ovf.
REQ-023 Start with i_len==0 or i_len>MAX_LEN SHALL be rejected: o_err pulses, FSM stays IDLE.
REQ-024 Start edges in ACCUM or OUT SHALL be ignored, with no o_err.
REQ-025 o_ready SHALL equal (state==ACCUM), combinational from the state register.
REQ-026 Each handshake SHALL add zero-extended i_data[c] to acc[c] for all channels in the same cycle and increment the counter.
REQ-027 Handshake with counter==len-1 SHALL load o_sum with final sums including that sample, set o_sum_valid and enter OUT next cycle.
REQ-028 Latency: len=L with continuous i_valid -> o_sum_valid high L cycles after ACCUM entry.
REQ-029 o_sum and o_sum_valid SHALL hold stable in OUT until i_sum_ready=1.
REQ-030 On OUT with i_sum_ready=1: o_sum_valid SHALL clear, o_done pulses next cycle, FSM returns to IDLE.
REQ-031 o_sum SHALL retain its value in IDLE.
REQ-032 Saturate mode: when acc+sample exceeds 2^SIZE_SUM-1, acc SHALL clamp to 2^SIZE_SUM-1 and set o_ovf[c].
REQ-033 Wrap mode: acc SHALL wrap modulo 2^SIZE_SUM and set o_ovf[c].
REQ-034 o_ovf SHALL be sticky until the next accepted start.
REQ-035 A start edge coincident with o_done SHALL be accepted, since the FSM is IDLE that cycle.

Reset
REQ-036 Asserting i_rst_n=0 SHALL asynchronously clear state to IDLE, acc, counter, o_sum, o_sum_valid, o_ovf, o_done, o_err, o_busy and the edge-detector register.
REQ-037 Reset mid-window SHALL discard the partial sums.
REQ-038 A high i_start at reset release SHALL NOT count as an edge until it falls and rises again.

Structure
REQ-039 Shared package ss_pkg SHALL hold the state enum type and the len-width helper function.
REQ-040 The design SHALL have one sub-module, ss_detect_edge: parametrised rising/falling detector with a registered output.
REQ-041 Per-channel accumulate/saturate logic SHALL be a generate loop, not a sub-module.

Verification
REQ-042 N_CH=4, SIZE_DATA=8, len=4, data ch0..3 = {1,2,3,4} each cycle, i_valid held 1 -> o_sum = {4,8,12,16}, o_ovf=0, o_done once.
REQ-043 len=3 with i_valid toggling 1,0,1,0,1 and ch0 samples 10,20,30 -> ch0 sum = 60, o_sum_valid after the 3rd handshake only.
REQ-044 SIZE_SUM=9, sat mode, len=3, ch0=255 x3 -> ch0 = 511, o_ovf[0]=1; same stimulus in wrap mode -> ch0 = 765 mod 512 = 253, o_ovf[0]=1.
REQ-045 Start with i_len=0 -> o_err pulse, o_busy stays 0; start edge during ACCUM -> ignored, sums unaffected.
REQ-046 i_sum_ready held 0 for 5 cycles in OUT -> o_sum stable; reset asserted after 2 of 4 samples -> all outputs 0, next window sums from zero.
